fetch_stage: RTL and testbench

Instruction-fetch stage of the teaching MIPS CPU. Holds the PC and drives the word address into the asynchronous instruction ROM. Latches the returned instruction word together with its PC into an IF/ID output register, which feeds the decode stage through a valid/allow handshake. The stage takes redirects (branch/jump) from downstream and stops fetching when the PC leaves the populated ROM range.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_inst_counter.sv | 31 +++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ============================================================
// fetch_stage_pkg : shared encodings and defaults for the IF stage
// Rev 1.0
// ============================================================
`default_nettype none

package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fs_state_e;

  localparam logic [31:0] FS_PC_RESET_DEFAULT  = 32'h0000_0000;
  localparam int          FS_ROM_DEPTH_DEFAULT = 21;
  localparam logic [31:0] FS_NOP               = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_inst_counter.sv
// ============================================================
// fetch_inst_counter : wrapping count of instructions handed to decode
// Present only when FETCH_INST_CNT_EN is defined
// Rev 1.0
// ============================================================
`default_nettype none

`ifdef FETCH_INST_CNT_EN
module fetch_inst_counter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================
// fetch_stage : MIPS IF stage - PC, ROM addressing, IF/ID register
// Optional: FETCH_INST_CNT_EN adds the transfer counter on fetch_cnt
// Rev 1.0
// ============================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = FS_PC_RESET_DEFAULT,
  parameter int          ROM_AW    = 5,
  parameter int          ROM_DEPTH = FS_ROM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              id_allow_in,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              if_halted,
  output logic [31:0]       fetch_cnt
);

  localparam logic [29:0] c_rom_depth = 30'(ROM_DEPTH);

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;

  logic w_xfer;
  logic w_can_adv;
  logic w_in_range;
  logic w_tgt_unused;

  assign w_xfer       = if_valid_q && id_allow_in;
  assign w_can_adv    = !if_valid_q || id_allow_in;
  assign w_in_range   = pc_q[31:2] < c_rom_depth;
  assign w_tgt_unused = ^br_target[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    // Default drains the held word once decode takes it.
    if_valid_d = if_valid_q && !id_allow_in;

    if (br_taken) begin
      pc_d       = {br_target[31:2], 2'b00};
      if_valid_d = 1'b0;
      state_d    = FS_RUN;
    end else begin
      case (state_q)
        FS_BOOT: state_d = FS_RUN;
        FS_RUN: begin
          if (w_can_adv) begin
            if (w_in_range) begin
              pc_d       = pc_q + 32'd4;
              if_pc_d    = pc_q;
              if_inst_d  = rom_inst;
              if_valid_d = 1'b1;
            end else begin
              state_d = FS_HALT;
            end
          end
        end
        FS_HALT: state_d = FS_HALT;
        default: state_d = FS_BOOT;
      endcase
    end

    halted_d = (state_d == FS_HALT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FS_BOOT;
      pc_q       <= PC_RESET;
      if_pc_q    <= '0;
      if_inst_q  <= FS_NOP;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign rom_addr  = pc_q[ROM_AW+1:2];
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_halted = halted_q;

`ifdef FETCH_INST_CNT_EN
  // Squashed transfers on a redirect edge are not counted.
  logic w_cnt_inc;
  assign w_cnt_inc = w_xfer && !br_taken;

  fetch_inst_counter u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc_i  (w_cnt_inc),
    .cnt_o  (fetch_cnt)
  );
`else
  logic w_xfer_unused;
  assign w_xfer_unused = w_xfer;
  assign fetch_cnt     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================
// tb_fetch_stage : directed vector bench for fetch_stage
// Rev 1.0
// ============================================================
`default_nettype none

module tb_fetch_stage;

  typedef struct {
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        ehalt;
    logic [4:0]  eaddr;
  } vec_t;

`ifdef FETCH_INST_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [4:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_allow_in;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_halted;
  logic [31:0] fetch_cnt;

  logic [31:0] rom_mem [0:31];
  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_mis = 0;

  assign rom_inst = rom_mem[rom_addr];

  fetch_stage dut (
    .clk         (clk),
    .resetn      (resetn),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_allow_in (id_allow_in),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_halted   (if_halted),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic a, input logic b, input logic [31:0] t,
                              input logic v, input logic [31:0] p, input logic [31:0] i,
                              input logic h, input logic [4:0] ad);
    vec_t r;
    r.allow = a; r.br = b; r.tgt = t; r.ev = v;
    r.epc = p; r.einst = i; r.ehalt = h; r.eaddr = ad;
    vecs.push_back(r);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"},  {31'd0, if_valid},  32'd0);
    chk({tag, "_pc"},     if_pc,              32'd0);
    chk({tag, "_inst"},   if_inst,            32'd0);
    chk({tag, "_halted"}, {31'd0, if_halted}, 32'd0);
    chk({tag, "_cnt"},    fetch_cnt,          32'd0);
    chk({tag, "_addr"},   {27'd0, rom_addr},  32'd0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rom_mem[k] = (k < 21) ? (32'hA5A5_0000 | k) : (32'hBAD0_0000 | k);
    rom_mem[0]  = 32'h2401_0001;
    rom_mem[1]  = 32'h0001_1100;
    rom_mem[2]  = 32'h0041_1821;
    rom_mem[3]  = 32'h0002_2082;
    rom_mem[12] = 32'h2401_0004;
    rom_mem[13] = 32'h8C2A_0013;
    rom_mem[20] = 32'h0800_0000;

    //   allow br  target      valid pc        inst           halt addr
    add(1, 0, 32'h0, 0, 32'h00, 32'h0,           0, 5'd0);  // BOOT edge
    add(1, 0, 32'h0, 1, 32'h00, 32'h2401_0001,   0, 5'd1);
    add(1, 0, 32'h0, 1, 32'h04, 32'h0001_1100,   0, 5'd2);
    add(1, 0, 32'h0, 1, 32'h08, 32'h0041_1821,   0, 5'd3);
    add(0, 0, 32'h0, 1, 32'h08, 32'h0041_1821,   0, 5'd3);  // stall x3
    add(0, 0, 32'h0, 1, 32'h08, 32'h0041_1821,   0, 5'd3);
    add(0, 0, 32'h0, 1, 32'h08, 32'h0041_1821,   0, 5'd3);
    add(1, 0, 32'h0, 1, 32'h0C, 32'h0002_2082,   0, 5'd4);
    add(1, 0, 32'h0, 1, 32'h10, 32'hA5A5_0004,   0, 5'd5);
    add(1, 0, 32'h0, 1, 32'h14, 32'hA5A5_0005,   0, 5'd6);
    add(1, 0, 32'h0, 1, 32'h18, 32'hA5A5_0006,   0, 5'd7);
    add(1, 0, 32'h0, 1, 32'h1C, 32'hA5A5_0007,   0, 5'd8);
    add(1, 0, 32'h0, 1, 32'h20, 32'hA5A5_0008,   0, 5'd9);
    add(1, 0, 32'h0, 1, 32'h24, 32'hA5A5_0009,   0, 5'd10);
    add(1, 0, 32'h0, 1, 32'h28, 32'hA5A5_000A,   0, 5'd11);
    add(1, 0, 32'h0, 1, 32'h2C, 32'hA5A5_000B,   0, 5'd12);
    add(1, 0, 32'h0, 1, 32'h30, 32'h2401_0004,   0, 5'd13);
    add(1, 1, 32'h36, 0, 32'h0, 32'h0,           0, 5'd13); // redirect squashes 0x30
    add(1, 0, 32'h0, 1, 32'h34, 32'h8C2A_0013,   0, 5'd14);
    add(1, 0, 32'h0, 1, 32'h38, 32'hA5A5_000E,   0, 5'd15);
    add(1, 0, 32'h0, 1, 32'h3C, 32'hA5A5_000F,   0, 5'd16);
    add(1, 0, 32'h0, 1, 32'h40, 32'hA5A5_0010,   0, 5'd17);
    add(1, 0, 32'h0, 1, 32'h44, 32'hA5A5_0011,   0, 5'd18);
    add(1, 0, 32'h0, 1, 32'h48, 32'hA5A5_0012,   0, 5'd19);
    add(1, 0, 32'h0, 1, 32'h4C, 32'hA5A5_0013,   0, 5'd20);
    add(1, 0, 32'h0, 1, 32'h50, 32'h0800_0000,   0, 5'd21);
    add(0, 0, 32'h0, 1, 32'h50, 32'h0800_0000,   0, 5'd21); // stalled at range end: no halt yet
    add(1, 0, 32'h0, 0, 32'h0, 32'h0,            1, 5'd21); // 0x50 transfers, halt
    add(1, 0, 32'h0, 0, 32'h0, 32'h0,            1, 5'd21);
    add(1, 1, 32'h0, 0, 32'h0, 32'h0,            0, 5'd0);  // redirect out of HALT
    add(1, 0, 32'h0, 1, 32'h00, 32'h2401_0001,   0, 5'd1);
    add(1, 0, 32'h0, 1, 32'h04, 32'h0001_1100,   0, 5'd2);

    resetn      = 1'b0;
    id_allow_in = 1'b1;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    repeat (2) step();
    chk_reset("rst");
    resetn = 1'b1;

    foreach (vecs[n]) begin
      id_allow_in = vecs[n].allow;
      br_taken    = vecs[n].br;
      br_target   = vecs[n].tgt;
      step();
      br_taken    = 1'b0;
      chk($sformatf("v%0d_valid", n),  {31'd0, if_valid},  {31'd0, vecs[n].ev});
      chk($sformatf("v%0d_halted", n), {31'd0, if_halted}, {31'd0, vecs[n].ehalt});
      chk($sformatf("v%0d_addr", n),   {27'd0, rom_addr},  {27'd0, vecs[n].eaddr});
      if (vecs[n].ev) begin
        chk($sformatf("v%0d_pc", n),   if_pc,   vecs[n].epc);
        chk($sformatf("v%0d_inst", n), if_inst, vecs[n].einst);
      end
    end

    // Counter sequence: 5 transfers, redirect (squashed transfer), 2 transfers.
    resetn = 1'b0;
    #1;
    resetn      = 1'b1;
    id_allow_in = 1'b1;
    step();
    step();
    repeat (5) step();
    chk("cnt_pc5", if_pc, 32'h14);
    chk("cnt_5",   fetch_cnt, CNT_EN ? 32'd5 : 32'd0);
    br_taken  = 1'b1;
    br_target = 32'h08;
    step();
    br_taken  = 1'b0;
    chk("cnt_redir_valid", {31'd0, if_valid}, 32'd0);
    chk("cnt_redir",       fetch_cnt, CNT_EN ? 32'd5 : 32'd0);
    repeat (3) step();
    chk("cnt_pc7", if_pc, 32'h10);
    chk("cnt_7",   fetch_cnt, CNT_EN ? 32'd7 : 32'd0);

    // Asynchronous reset while 0x10 is held.
    #2;
    resetn = 1'b0;
    #1;
    chk_reset("midrst");
    resetn = 1'b1;
    step();
    chk("restart_boot_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("restart_valid", {31'd0, if_valid}, 32'd1);
    chk("restart_pc",    if_pc,   32'h00);
    chk("restart_inst",  if_inst, 32'h2401_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
